// File: rtl/board_row_reader_pkg.sv
// Shared board geometry and scanner state encoding for the Tetris board
// read-side logic.
package board_row_reader_pkg;

  localparam int BOARD_ROWS   = 20;
  localparam int BOARD_COLS   = 10;
  localparam int BOARD_ROW_AW = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

endpackage

// File: rtl/board_row_full_detect.sv
// Combinational row classifier: all cells occupied / no cell occupied.
// Shared by the row reader, line-clear and spawn-collision logic.
module board_row_full_detect #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] row_bits,
  output logic            all_ones,
  output logic            all_zero
);

  assign all_ones = &row_bits;
  assign all_zero = ~|row_bits;

endmodule

// File: rtl/board_row_reader.sv
// Bottom-up board scanner reporting completely filled rows over valid/ready.
// Define BOARD_ROW_READER_EMPTY_STOP_EN to end the scan at the first empty row.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | rd_en high, rd_addr = row
// SAMPLE | rd_data valid, classify row
// EMIT   | full_row offered to consumer
// FINISH | done pulse, back to IDLE
module board_row_reader
  import board_row_reader_pkg::*;
#(
  parameter int ROWS   = BOARD_ROWS,
  parameter int COLS   = BOARD_COLS,
  parameter int ROW_AW = BOARD_ROW_AW
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [COLS-1:0]   rd_data,
  output logic              full_valid,
  output logic [ROW_AW-1:0] full_row,
  input  logic              full_ready,
  output logic              busy,
  output logic              done,
  output logic [ROW_AW:0]   full_count
);

  localparam logic [ROW_AW-1:0] ROW_TOP = ROW_AW'(ROWS - 1);

  logic [2:0]        state, state_nxt;
  logic [ROW_AW-1:0] row, row_nxt;
  logic              row_full;
  logic              row_empty;
  logic              stop_early;
  logic              last_row;

  board_row_full_detect #(.COLS(COLS)) u_full_detect (
    .row_bits (rd_data),
    .all_ones (row_full),
    .all_zero (row_empty)
  );

`ifdef BOARD_ROW_READER_EMPTY_STOP_EN
  // Pieces stack from the bottom, so nothing can sit above an empty row.
  assign stop_early = row_empty;
`else
  logic row_empty_unused;
  assign row_empty_unused = row_empty;
  assign stop_early       = 1'b0;
`endif

  assign last_row = (row == '0);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_READ;
          row_nxt   = ROW_TOP;
        end
      end
      ST_READ: state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        if (row_full) begin
          state_nxt = ST_EMIT;
        end else if (last_row || stop_early) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_READ;
          row_nxt   = row - ROW_AW'(1);
        end
      end
      ST_EMIT: begin
        if (full_ready) begin
          if (last_row) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = ST_READ;
            row_nxt   = row - ROW_AW'(1);
          end
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      row        <= ROW_TOP;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      full_valid <= 1'b0;
      full_row   <= '0;
      full_count <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      // Registered strobe so rd_en/rd_addr line up exactly with the READ state.
      rd_en <= (state_nxt == ST_READ);
      if (state_nxt == ST_READ) begin
        rd_addr <= row_nxt;
      end
      if (state == ST_IDLE && start) begin
        full_count <= '0;
      end
      if (state == ST_SAMPLE && row_full) begin
        full_valid <= 1'b1;
        full_row   <= row;
      end
      if (state == ST_EMIT && full_ready) begin
        full_valid <= 1'b0;
        full_count <= full_count + (ROW_AW + 1)'(1);
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule
